// File: rtl/lsu_mem_ctrl_if.sv
// rtl/lsu_mem_ctrl_if.sv - request/response bundle between a load/store unit and lsu_mem_ctrl
//
// Purpose: groups the request and response valid/ready channels of the data-memory controller.
// Signals:
//   req_valid/req_ready   request handshake (master -> slave / slave -> master)
//   req_wr                1 = store, 0 = load
//   req_size              00 byte, 01 half, 10 word, 11 illegal
//   req_signed            load extension select (1 = sign, 0 = zero)
//   req_addr              byte address, ADDR_W bits
//   req_wdata             right-aligned store data
//   resp_valid/resp_ready response handshake (slave -> master / master -> slave)
//   resp_rdata            extended load result, 0 for stores and faults
//   resp_err              access faulted
// Modports: master (load/store unit side), slave (controller side).

interface lsu_mem_ctrl_if #(
    parameter int ADDR_W = 32
) ();
    logic              req_valid;
    logic              req_ready;
    logic              req_wr;
    logic [1:0]        req_size;
    logic              req_signed;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic              resp_ready;
    logic [31:0]       resp_rdata;
    logic              resp_err;

    modport master (
        output req_valid, req_wr, req_size, req_signed, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_wr, req_size, req_signed, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// rtl/lsu_mem_ctrl.sv - multi-cycle data-memory controller with byte/half/word access
//
// Purpose: word-addressed storage array behind a valid/ready request/response handshake,
// with access-size decode, byte enables, sign/zero extension, fault detection and a
// configurable access latency. At most one request is outstanding.
// Ports:
//   clk   clock, all state updates on the rising edge
//   rst   synchronous active-high reset
//   bus   lsu_mem_ctrl_if.slave (request/response channels)
// Parameters: ADDR_W byte-address width, DEPTH words (power of two, >= 2), LATENCY >= 1.
// Optional build macro: LSU_MEM_CTRL_TRACE_EN prints one trace line per performed access.

module lsu_mem_ctrl #(
    parameter int ADDR_W  = 32,
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 1
) (
    input  logic clk,
    input  logic rst,
    lsu_mem_ctrl_if.slave bus
);
    localparam int IDX_W = $clog2(DEPTH);
    // The counter only has to reach LATENCY-1.
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATENCY - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    logic [1:0]        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_wr;
    logic [1:0]        r_size;
    logic              r_signed;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [31:0]       r_rdata;
    logic              r_err;
    logic [31:0]       r_mem [DEPTH];

    logic              w_in_idle;
    logic              w_do_access;
    logic              w_acc_wr;
    logic [1:0]        w_acc_size;
    logic              w_acc_signed;
    logic [ADDR_W-1:0] w_acc_addr;
    logic [31:0]       w_acc_wdata;
    logic              w_misalign;
    logic              w_oor;
    logic              w_acc_err;
    logic [IDX_W-1:0]  w_idx;
    logic [1:0]        w_lane;
    logic [3:0]        w_be;
    logic [31:0]       w_wword;
    logic [31:0]       w_rword;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [31:0]       w_load;
    logic [31:0]       w_resp_rdata;
    logic              w_mem_we;

    assign w_in_idle = (r_state == ST_IDLE);

    // With LATENCY == 1 the access happens on the accept edge itself, so the
    // access operands come straight from the bus; otherwise from the latched copy.
    assign w_acc_wr     = w_in_idle ? bus.req_wr     : r_wr;
    assign w_acc_size   = w_in_idle ? bus.req_size   : r_size;
    assign w_acc_signed = w_in_idle ? bus.req_signed : r_signed;
    assign w_acc_addr   = w_in_idle ? bus.req_addr   : r_addr;
    assign w_acc_wdata  = w_in_idle ? bus.req_wdata  : r_wdata;

    assign w_do_access = (w_in_idle && bus.req_valid && (LATENCY == 1)) ||
                         ((r_state == ST_BUSY) && (r_cnt == CNT_LAST));

    assign w_idx  = w_acc_addr[IDX_W+1:2];
    assign w_lane = w_acc_addr[1:0];

    always_comb begin
        w_misalign = 1'b0;
        case (w_acc_size)
            SZ_HALF: w_misalign = w_acc_addr[0];
            SZ_WORD: w_misalign = (w_acc_addr[1:0] != 2'b00);
            default: w_misalign = 1'b0;
        endcase
    end

    // Any address bit above the array's byte range makes the access out of range.
    assign w_oor     = ((w_acc_addr >> (IDX_W + 2)) != '0);
    assign w_acc_err = (w_acc_size == 2'b11) || w_misalign || w_oor;

    // Store data is replicated across lanes so the byte enable alone selects
    // where it lands.
    always_comb begin
        w_be    = 4'b0000;
        w_wword = w_acc_wdata;
        case (w_acc_size)
            SZ_BYTE: begin
                w_be    = 4'b0001 << w_lane;
                w_wword = {4{w_acc_wdata[7:0]}};
            end
            SZ_HALF: begin
                w_be    = 4'b0011 << w_lane;
                w_wword = {2{w_acc_wdata[15:0]}};
            end
            SZ_WORD: begin
                w_be    = 4'b1111;
                w_wword = w_acc_wdata;
            end
            default: begin
                w_be    = 4'b0000;
                w_wword = w_acc_wdata;
            end
        endcase
    end

    assign w_rword = r_mem[w_idx];

    always_comb begin
        w_byte = w_rword[7:0];
        case (w_lane)
            2'd0:    w_byte = w_rword[7:0];
            2'd1:    w_byte = w_rword[15:8];
            2'd2:    w_byte = w_rword[23:16];
            default: w_byte = w_rword[31:24];
        endcase
    end

    assign w_half = w_lane[1] ? w_rword[31:16] : w_rword[15:0];

    always_comb begin
        w_load = w_rword;
        case (w_acc_size)
            SZ_BYTE: w_load = w_acc_signed ? {{24{w_byte[7]}}, w_byte} : {24'd0, w_byte};
            SZ_HALF: w_load = w_acc_signed ? {{16{w_half[15]}}, w_half} : {16'd0, w_half};
            default: w_load = w_rword;
        endcase
    end

    assign w_resp_rdata = (w_acc_wr || w_acc_err) ? 32'd0 : w_load;

    // Reset in the access cycle suppresses the write: an in-flight request is dropped whole.
    assign w_mem_we = !rst && w_do_access && w_acc_wr && !w_acc_err;

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) begin
                    r_mem[w_idx][8*b +: 8] <= w_wword[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_wr     <= 1'b0;
            r_size   <= 2'b00;
            r_signed <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_rdata  <= '0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        r_wr     <= bus.req_wr;
                        r_size   <= bus.req_size;
                        r_signed <= bus.req_signed;
                        r_addr   <= bus.req_addr;
                        r_wdata  <= bus.req_wdata;
                        if (LATENCY == 1) begin
                            r_state <= ST_RESP;
                        end else begin
                            r_state <= ST_BUSY;
                            r_cnt   <= CNT_W'(1);
                        end
                    end
                end
                ST_BUSY: begin
                    if (r_cnt == CNT_LAST) begin
                        r_state <= ST_RESP;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    if (bus.resp_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase

            if (w_do_access) begin
                r_rdata <= w_resp_rdata;
                r_err   <= w_acc_err;
            end
        end
    end

`ifdef LSU_MEM_CTRL_TRACE_EN
    always_ff @(posedge clk) begin
        if (!rst && w_do_access) begin
            $display("LSU %s addr=0x%08h size=%0d data=0x%08h err=%0b",
                     w_acc_wr ? "W" : "R", w_acc_addr, w_acc_size,
                     w_acc_wr ? w_acc_wdata : w_resp_rdata, w_acc_err);
        end
    end
`else
`endif

    assign bus.req_ready  = (r_state == ST_IDLE);
    assign bus.resp_valid = (r_state == ST_RESP);
    assign bus.resp_rdata = r_rdata;
    assign bus.resp_err   = r_err;
endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb/tb_lsu_mem_ctrl.sv - scoreboard bench for lsu_mem_ctrl with a byte-array reference model

module tb_lsu_mem_ctrl;
    localparam int ADDR_W  = 16;
    localparam int DEPTH   = 64;
    localparam int LATENCY = 4;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lsu_mem_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

    lsu_mem_ctrl #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH),
        .LATENCY(LATENCY)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    exp_t       exp_q[$];
    logic [7:0] mem_m [DEPTH*4];
    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int acc_cyc  = 0;
    int n_issued = 0;
    int n_resp   = 0;
    int bp_mode  = 0;
    logic prev_valid = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference model: memory as a flat byte array, access rules from the size/alignment table.
    task automatic model(input logic wr, input logic [1:0] size, input logic sgn,
                         input logic [15:0] addr, input logic [31:0] wdata, output exp_t e);
        int nb;
        logic [31:0] v;
        nb = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        e.err   = (size == 2'd3) || ((int'(addr) % nb) != 0) || (int'(addr) >= DEPTH*4);
        e.rdata = 32'd0;
        if (!e.err) begin
            if (wr) begin
                for (int i = 0; i < nb; i++) mem_m[int'(addr) + i] = wdata[8*i +: 8];
            end else begin
                v = 32'd0;
                for (int i = 0; i < nb; i++) v = v | (32'(mem_m[int'(addr) + i]) << (8*i));
                if (sgn && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8*nb));
                e.rdata = v;
            end
        end
    endtask

    task automatic drive_idle();
        bus.req_valid  = 1'b0;
        bus.req_wr     = 1'($urandom);
        bus.req_size   = 2'($urandom);
        bus.req_signed = 1'($urandom);
        bus.req_addr   = 16'($urandom);
        bus.req_wdata  = $urandom;
    endtask

    task automatic wait_done();
        for (int k = 0; k < 200 && n_resp < n_issued; k++) @(negedge clk);
        if (n_resp < n_issued) check("resp_timeout", 32'(n_resp), 32'(n_issued));
    endtask

    task automatic issue(input logic wr, input logic [1:0] size, input logic sgn,
                         input logic [15:0] addr, input logic [31:0] wdata,
                         input logic use_exp, input logic [31:0] xr, input logic xe,
                         input logic wait_resp);
        exp_t e;
        logic accepted;
        model(wr, size, sgn, addr, wdata, e);
        if (use_exp) begin
            e.rdata = xr;
            e.err   = xe;
        end
        exp_q.push_back(e);
        n_issued++;
        @(posedge clk); #1;
        bus.req_valid  = 1'b1;
        bus.req_wr     = wr;
        bus.req_size   = size;
        bus.req_signed = sgn;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        accepted = 1'b0;
        for (int k = 0; k < 50 && !accepted; k++) begin
            @(negedge clk);
            if (bus.req_ready) begin
                accepted = 1'b1;
                acc_cyc  = cyc;
            end
        end
        if (!accepted) check("accept_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        drive_idle();
        if (wait_resp) wait_done();
    endtask

    task automatic dir(input logic wr, input logic [1:0] size, input logic sgn,
                       input logic [15:0] addr, input logic [31:0] wdata,
                       input logic [31:0] xr, input logic xe);
        issue(wr, size, sgn, addr, wdata, 1'b1, xr, xe, 1'b1);
    endtask

    task automatic mdl(input logic wr, input logic [1:0] size, input logic sgn,
                       input logic [15:0] addr, input logic [31:0] wdata);
        issue(wr, size, sgn, addr, wdata, 1'b0, 32'd0, 1'b0, 1'b1);
    endtask

    // Monitor: pops the scoreboard on every response handshake.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            prev_valid = 1'b0;
        end else begin
            if (bus.resp_valid && !prev_valid) begin
                if (exp_q.size() == 0) check("unexpected_resp", 32'd1, 32'd0);
                else check("latency", 32'(cyc - acc_cyc), 32'(LATENCY));
            end
            if (bus.resp_valid && bus.resp_ready && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("resp_rdata", bus.resp_rdata, e.rdata);
                check("resp_err", {31'd0, bus.resp_err}, {31'd0, e.err});
                n_resp++;
            end
            prev_valid = bus.resp_valid;
        end
    end

    initial begin
        bus.resp_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (bp_mode)
                0:       bus.resp_ready = 1'b1;
                1:       bus.resp_ready = ($urandom_range(0, 3) != 0);
                default: bus.resp_ready = 1'b0;
            endcase
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: run did not finish, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  sz;
        logic [15:0] ad;
        int          vcount;
        logic        accepted;
        drive_idle();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
        check("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        check("rst_resp_rdata", bus.resp_rdata, 32'd0);
        check("rst_resp_err", {31'd0, bus.resp_err}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Give every word a known value so the model tracks the whole array.
        for (int w = 0; w < DEPTH; w++) mdl(1'b1, 2'd2, 1'b0, 16'(w * 4), $urandom);

        dir(1'b1, 2'd2, 1'b0, 16'h0010, 32'hDEAD_BEEF, 32'd0, 1'b0);
        dir(1'b0, 2'd2, 1'b0, 16'h0010, 32'd0, 32'hDEAD_BEEF, 1'b0);
        dir(1'b1, 2'd0, 1'b0, 16'h0013, 32'h0000_007F, 32'd0, 1'b0);
        dir(1'b0, 2'd2, 1'b0, 16'h0010, 32'd0, 32'h7FAD_BEEF, 1'b0);
        dir(1'b0, 2'd0, 1'b1, 16'h0012, 32'd0, 32'hFFFF_FFAD, 1'b0);
        dir(1'b0, 2'd0, 1'b0, 16'h0012, 32'd0, 32'h0000_00AD, 1'b0);
        dir(1'b1, 2'd1, 1'b0, 16'h0020, 32'h0000_8001, 32'd0, 1'b0);
        dir(1'b0, 2'd1, 1'b1, 16'h0020, 32'd0, 32'hFFFF_8001, 1'b0);
        dir(1'b0, 2'd1, 1'b0, 16'h0020, 32'd0, 32'h0000_8001, 1'b0);
        dir(1'b0, 2'd1, 1'b0, 16'h0021, 32'd0, 32'd0, 1'b1);
        dir(1'b1, 2'd2, 1'b0, 16'h0022, 32'h1234_5678, 32'd0, 1'b1);
        dir(1'b0, 2'd1, 1'b0, 16'h0020, 32'd0, 32'h0000_8001, 1'b0);
        dir(1'b0, 2'd2, 1'b0, 16'(DEPTH * 4), 32'd0, 32'd0, 1'b1);
        dir(1'b0, 2'd3, 1'b0, 16'h0010, 32'd0, 32'd0, 1'b1);
        dir(1'b1, 2'd3, 1'b0, 16'h0014, 32'hFFFF_FFFF, 32'd0, 1'b1);
        mdl(1'b0, 2'd2, 1'b0, 16'h0014, 32'd0);

        // Response back-pressure: outputs must hold while resp_ready is low.
        @(negedge clk);
        bp_mode = 2;
        issue(1'b0, 2'd2, 1'b0, 16'h0010, 32'd0, 1'b1, 32'h7FAD_BEEF, 1'b0, 1'b0);
        for (int k = 0; k < 50 && !bus.resp_valid; k++) @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            check("stall_resp_valid", {31'd0, bus.resp_valid}, 32'd1);
            check("stall_req_ready", {31'd0, bus.req_ready}, 32'd0);
            check("stall_resp_rdata", bus.resp_rdata, 32'h7FAD_BEEF);
            check("stall_resp_err", {31'd0, bus.resp_err}, 32'd0);
            @(negedge clk);
        end
        bp_mode = 0;
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        check("release_req_ready", {31'd0, bus.req_ready}, 32'd1);
        check("release_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        wait_done();

        // Reset while a store is in flight: the store must not commit, no response appears.
        dir(1'b1, 2'd2, 1'b0, 16'h0030, 32'hCAFE_F00D, 32'd0, 1'b0);
        @(posedge clk); #1;
        bus.req_valid  = 1'b1;
        bus.req_wr     = 1'b1;
        bus.req_size   = 2'd0;
        bus.req_signed = 1'b0;
        bus.req_addr   = 16'h0030;
        bus.req_wdata  = 32'h0000_0055;
        accepted = 1'b0;
        for (int k = 0; k < 50 && !accepted; k++) begin
            @(negedge clk);
            if (bus.req_ready) accepted = 1'b1;
        end
        check("rst_test_accept", {31'd0, accepted}, 32'd1);
        @(posedge clk); #1;
        drive_idle();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        vcount = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (bus.resp_valid) vcount++;
        end
        check("no_stale_resp", 32'(vcount), 32'd0);
        check("post_rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
        dir(1'b0, 2'd2, 1'b0, 16'h0030, 32'd0, 32'hCAFE_F00D, 1'b0);

        // Randomized traffic with random response back-pressure.
        bp_mode = 1;
        for (int n = 0; n < 80; n++) begin
            sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            ad = 16'($urandom_range(0, DEPTH * 4 + 31));
            if ($urandom_range(0, 1) != 0) begin
                if (sz == 2'd1) ad[0] = 1'b0;
                if (sz == 2'd2) ad[1:0] = 2'b00;
            end
            mdl(1'($urandom), sz, 1'($urandom), ad, $urandom);
        end
        bp_mode = 0;

        wait_done();
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
- Parametrised, synthesizable data-memory controller with an internal word-addressed storage array.
- Successor to the combinational DPI data-memory path; serves the multi-cycle/pipelined core.
- Adds byte/half/word access sizes, sign/zero extension, configurable access latency and a valid/ready request/response handshake.
- Detects misaligned, out-of-range and illegal-size accesses; at most one request outstanding.

Parameters:
- ADDR_W, 32: byte-address width.
- DEPTH, 1024: storage depth in 32-bit words; power of two, >= 2.
- LATENCY, 1: cycles from request accept to resp_valid; integer >= 1.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  controller can accept a request.
- req_wr  input  1  1 = store, 0 = load.
- req_size  input  2  00 byte, 01 half, 10 word, 11 illegal.
- req_signed  input  1  loads only: 1 = sign-extend, 0 = zero-extend.
- req_addr  input  ADDR_W  byte address.
- req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- resp_valid  output  1  response present.
- resp_ready  input  1  consumer accepts the response.
- resp_rdata  output  32  load result, extended; 0 for stores and errors.
- resp_err  output  1  access faulted.

Behaviour:
- Reset: state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, latency counter=0. Storage array contents are not cleared.
- FSM states: IDLE, BUSY, RESP.
- IDLE: req_ready=1. On req_valid, latch wr/size/signed/addr/wdata. Go to BUSY if LATENCY>1, else perform the access and go to RESP.
- BUSY: req_ready=0; counter counts 1..LATENCY-1. On the final count, perform the access and go to RESP.
- RESP: resp_valid=1; resp_rdata/resp_err held stable. On resp_ready go to IDLE. No new request is accepted in the same cycle as the response handshake.
- Timing: accept at edge T -> resp_valid first high in cycle T+LATENCY. Back-to-back throughput is one access per LATENCY+1 cycles, with resp_ready tied high.
- Error conditions: size 11; half with addr[0]=1; word with addr[1:0]!=0; addr >= DEPTH*4 (upper address bits nonzero).
- On error: no array write, resp_err=1, resp_rdata=0.
- Index: word index is addr[log2(DEPTH)+1:2]; byte lane is addr[1:0].
- Stores: the byte enable is derived from size and lane, e.g. byte at lane 3 -> be=1000, wdata[7:0] written to bits [31:24].
  - The write commits only at the access cycle, never at accept.
  - resp_rdata=0 for stores.
- Loads: the selected lane is shifted to bit 0, then sign- or zero-extended per req_signed. Word loads ignore req_signed.
- Read-after-write: a load issued after a store's response always observes the stored data.
- Reset mid-operation: any in-flight request is dropped. If the access cycle has not occurred, no write happens. No response is produced.
- Inputs other than req_valid are don't-care when no request is being accepted.

Optional Feature:
- Macro: LSU_MEM_CTRL_TRACE_EN.
- Defined: in simulation, each performed access prints "LSU W|R addr=0x%08h size=%0d data=0x%08h err=%0b" once, in the access cycle.
- Undefined: no display statements compiled; functional behaviour identical.

Test Plan:
- Reset, then store word 0xDEADBEEF @0x10, then load word @0x10 unsigned -> resp_rdata=0xDEADBEEF, resp_err=0, resp_valid first high exactly LATENCY cycles after each accept.
- After the above, store byte 0x7F @0x13, then load word @0x10 -> 0x7FADBEEF. Load byte signed @0x12 -> 0xFFFFFFAD. Load byte unsigned @0x12 -> 0x000000AD.
- Store half 0x8001 @0x20, then load half signed @0x20 -> 0xFFFF8001; load half unsigned -> 0x00008001. Load half @0x21 -> resp_err=1, resp_rdata=0.
- Store word 0x12345678 @0x22 (misaligned) -> resp_err=1; subsequent load @0x20 returns the prior contents unchanged. Load @DEPTH*4 -> resp_err=1. size=11 -> resp_err=1.
- Hold resp_ready=0 for 5 cycles in RESP -> resp_valid, resp_rdata and resp_err stable, req_ready=0 throughout. Release -> IDLE next cycle, req_ready=1.
- With LATENCY=4: accept store 0x55 @0x30, assert rst in cycle T+2, then load @0x30 -> previously written value (store not committed), and no stale response after reset.
